// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: parametrised raster timing, pixel-clock
// divider, four runtime-selectable patterns, data enable and pixel coordinates.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter int COLOR_W  = 4,
  parameter int SYNC_POL = 0,
  parameter int CHK_LOG2 = 5,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int YW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             MODE,
  input  logic [3*COLOR_W-1:0]   SOLID_RGB,
  output logic                   VGA_HSYNC,
  output logic                   VGA_VSYNC,
  output logic [COLOR_W-1:0]     VGA_RED,
  output logic [COLOR_W-1:0]     VGA_GREEN,
  output logic [COLOR_W-1:0]     VGA_BLUE,
  output logic                   DE,
  output logic [XW-1:0]          PIX_X,
  output logic [YW-1:0]          PIX_Y,
  output logic                   FRAME_START
);

  localparam logic        SYNC_ON  = (SYNC_POL != 0);
  localparam logic [31:0] H_ACT32  = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT32  = 32'(V_ACTIVE);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);

  logic tick;

  generate
    if (CLK_DIV <= 1) begin : g_no_div
      assign tick = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
      logic [DW-1:0] div_cnt_reg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          div_cnt_reg <= '0;
        end else if (div_cnt_reg == DIV_LAST) begin
          div_cnt_reg <= '0;
        end else begin
          div_cnt_reg <= div_cnt_reg + DW'(1);
        end
      end

      assign tick = (div_cnt_reg == DIV_LAST);
    end
  endgenerate

  // Raster position of the pixel about to be emitted on the next tick
  logic [XW-1:0] h_cnt_reg;
  logic [YW-1:0] v_cnt_reg;
  logic          h_last;
  logic          v_last;
  logic          frame_first;

  assign h_last      = (h_cnt_reg == H_LAST);
  assign v_last      = (v_cnt_reg == V_LAST);
  assign frame_first = (h_cnt_reg == '0) && (v_cnt_reg == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= v_last ? '0 : v_cnt_reg + YW'(1);
      end else begin
        h_cnt_reg <= h_cnt_reg + XW'(1);
      end
    end
  end

  // Bar index = number of thresholds k*ACTIVE/8 already reached, compared as pos*8 >= k*ACTIVE
  logic [6:0] h_ge;
  logic [6:0] v_ge;
  logic [2:0] h_bar;
  logic [2:0] v_bar;

  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar
      localparam logic [31:0] H_THR = 32'(gi * H_ACTIVE);
      localparam logic [31:0] V_THR = 32'(gi * V_ACTIVE);
      assign h_ge[gi-1] = ((32'(h_cnt_reg) << 3) >= H_THR);
      assign v_ge[gi-1] = ((32'(v_cnt_reg) << 3) >= V_THR);
    end
  endgenerate

  always_comb begin
    h_bar = '0;
    v_bar = '0;
    for (int k = 0; k < 7; k++) begin
      h_bar = h_bar + {2'b00, h_ge[k]};
      v_bar = v_bar + {2'b00, v_ge[k]};
    end
  end

  logic chk_h;
  logic chk_v;

  generate
    if (CHK_LOG2 < XW) begin : g_chk_h
      assign chk_h = h_cnt_reg[CHK_LOG2];
    end else begin : g_chk_h_zero
      assign chk_h = 1'b0;
    end
    if (CHK_LOG2 < YW) begin : g_chk_v
      assign chk_v = v_cnt_reg[CHK_LOG2];
    end else begin : g_chk_v_zero
      assign chk_v = 1'b0;
    end
  endgenerate

  // Code c = 7 - bar; G follows c[2], R follows c[1], B follows c[0], giving
  // white, yellow, cyan, green, magenta, red, blue, black across the screen.
  function automatic logic [3*COLOR_W-1:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] code;
    code = ~idx;
    return {{COLOR_W{code[1]}}, {COLOR_W{code[2]}}, {COLOR_W{code[0]}}};
  endfunction

  logic [1:0]           mode_reg;
  logic [3*COLOR_W-1:0] solid_reg;
  logic [1:0]           mode_eff;
  logic [3*COLOR_W-1:0] solid_eff;

  // Pixel (0,0) already belongs to the new frame, so it uses the live inputs
  assign mode_eff  = frame_first ? MODE : mode_reg;
  assign solid_eff = frame_first ? SOLID_RGB : solid_reg;

  logic                 hsync_next;
  logic                 vsync_next;
  logic                 de_next;
  logic [3*COLOR_W-1:0] rgb_next;

  always_comb begin
    hsync_next = ~SYNC_ON;
    vsync_next = ~SYNC_ON;
    de_next    = 1'b0;
    rgb_next   = '0;
    if ((32'(h_cnt_reg) >= HS_START) && (32'(h_cnt_reg) < HS_END)) begin
      hsync_next = SYNC_ON;
    end
    if ((32'(v_cnt_reg) >= VS_START) && (32'(v_cnt_reg) < VS_END)) begin
      vsync_next = SYNC_ON;
    end
    de_next = (32'(h_cnt_reg) < H_ACT32) && (32'(v_cnt_reg) < V_ACT32);
    if (de_next) begin
      case (mode_eff)
        2'd0:    rgb_next = bar_rgb(h_bar);
        2'd1:    rgb_next = bar_rgb(v_bar);
        2'd2:    rgb_next = (chk_h ^ chk_v) ? '1 : '0;
        default: rgb_next = solid_eff;
      endcase
    end
  end

  logic                 hsync_reg;
  logic                 vsync_reg;
  logic                 de_reg;
  logic [3*COLOR_W-1:0] rgb_reg;
  logic [XW-1:0]        pix_x_reg;
  logic [YW-1:0]        pix_y_reg;
  logic                 frame_start_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hsync_reg       <= ~SYNC_ON;
      vsync_reg       <= ~SYNC_ON;
      de_reg          <= 1'b0;
      rgb_reg         <= '0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      frame_start_reg <= 1'b0;
      mode_reg        <= '0;
      solid_reg       <= '0;
    end else begin
      frame_start_reg <= tick && frame_first;
      if (tick) begin
        hsync_reg <= hsync_next;
        vsync_reg <= vsync_next;
        de_reg    <= de_next;
        rgb_reg   <= rgb_next;
        pix_x_reg <= h_cnt_reg;
        pix_y_reg <= v_cnt_reg;
        if (frame_first) begin
          mode_reg  <= MODE;
          solid_reg <= SOLID_RGB;
        end
      end
    end
  end

  assign VGA_HSYNC   = hsync_reg;
  assign VGA_VSYNC   = vsync_reg;
  assign DE          = de_reg;
  assign VGA_RED     = rgb_reg[3*COLOR_W-1:2*COLOR_W];
  assign VGA_GREEN   = rgb_reg[2*COLOR_W-1:COLOR_W];
  assign VGA_BLUE    = rgb_reg[COLOR_W-1:0];
  assign PIX_X       = pix_x_reg;
  assign PIX_Y       = pix_y_reg;
  assign FRAME_START = frame_start_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: two small-raster instances (divided / undivided pixel clock)
// checked by a cycle-count reference model, a vector table and directed sequences.
`timescale 1ns/1ps
module tb_vga_pattern_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [1:0]  mode_a, mode_b;
  logic [11:0] solid_a, solid_b;
  logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic [3:0]  px_a, px_b;
  logic [2:0]  py_a, py_b;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(2), .COLOR_W(4), .SYNC_POL(0), .CHK_LOG2(1)
  ) u_dut_a (
    .CLK(clk), .RST(rst_a), .MODE(mode_a), .SOLID_RGB(solid_a),
    .VGA_HSYNC(hs_a), .VGA_VSYNC(vs_a), .VGA_RED(r_a), .VGA_GREEN(g_a), .VGA_BLUE(b_a),
    .DE(de_a), .PIX_X(px_a), .PIX_Y(py_a), .FRAME_START(fs_a)
  );

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(1), .COLOR_W(4), .SYNC_POL(1), .CHK_LOG2(2)
  ) u_dut_b (
    .CLK(clk), .RST(rst_b), .MODE(mode_b), .SOLID_RGB(solid_b),
    .VGA_HSYNC(hs_b), .VGA_VSYNC(vs_b), .VGA_RED(r_b), .VGA_GREEN(g_b), .VGA_BLUE(b_b),
    .DE(de_b), .PIX_X(px_b), .PIX_Y(py_b), .FRAME_START(fs_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic hs, input logic vs, input logic de,
                                       input logic fs, input logic [11:0] rgb,
                                       input logic [3:0] px, input logic [2:0] py);
    return {9'b0, hs, vs, de, fs, rgb, px, py};
  endfunction

  function automatic logic [11:0] bar_colour(input int i);
    case (i)
      0: return 12'hFFF;  // white
      1: return 12'hFF0;  // yellow
      2: return 12'h0FF;  // cyan
      3: return 12'h0F0;  // green
      4: return 12'hF0F;  // magenta
      5: return 12'hF00;  // red
      6: return 12'h00F;  // blue
      default: return 12'h000;
    endcase
  endfunction

  // Expected outputs n CLK edges after the reset edge, from the raster rules directly
  function automatic logic [31:0] ref_out(input int n, input int div, input logic pol,
                                          input int chk, input logic [1:0] fm,
                                          input logic [11:0] fsol);
    int p, h, v;
    logic hs, vs, de, fs;
    logic [11:0] rgb;
    if (n < div) return pack(~pol, ~pol, 1'b0, 1'b0, 12'h000, 4'h0, 3'h0);
    p   = n / div - 1;
    h   = p % HT;
    v   = (p / HT) % VT;
    fs  = (n % div == 0) && (h == 0) && (v == 0);
    hs  = (h >= HA + HF && h < HA + HF + HS) ? pol : ~pol;
    vs  = (v >= VA + VF && v < VA + VF + VS) ? pol : ~pol;
    de  = (h < HA) && (v < VA);
    rgb = 12'h000;
    if (de) begin
      case (fm)
        2'd0: rgb = bar_colour(h * 8 / HA);
        2'd1: rgb = bar_colour(v * 8 / VA);
        2'd2: rgb = ((((h >> chk) ^ (v >> chk)) & 1) != 0) ? 12'hFFF : 12'h000;
        default: rgb = fsol;
      endcase
    end
    return pack(hs, vs, de, fs, rgb, 4'(h), 3'(v));
  endfunction

  // Scoreboard: both instances checked one step after every edge
  int          na = 0, nb = 0;
  logic        va = 1'b0, vb = 1'b0;
  logic [1:0]  fma = '0, fmb = '0;
  logic [11:0] fsa = '0, fsb = '0;

  always begin
    @(posedge clk);
    if (rst_a) begin
      na = 0; va = 1'b1; fma = 2'd0; fsa = 12'h000;
    end else if (va) begin
      na++;
      if (na % 2 == 0 && ((na / 2 - 1) % FT) == 0) begin
        fma = mode_a; fsa = solid_a;
      end
    end
    if (rst_b) begin
      nb = 0; vb = 1'b1; fmb = 2'd0; fsb = 12'h000;
    end else if (vb) begin
      nb++;
      if (((nb - 1) % FT) == 0) begin
        fmb = mode_b; fsb = solid_b;
      end
    end
    #1;
    if (va) check("model_a", pack(hs_a, vs_a, de_a, fs_a, {r_a, g_a, b_a}, px_a, py_a),
                  ref_out(na, 2, 1'b0, 1, fma, fsa));
    if (vb) check("model_b", pack(hs_b, vs_b, de_b, fs_b, {r_b, g_b, b_b}, px_b, py_b),
                  ref_out(nb, 1, 1'b1, 2, fmb, fsb));
  end

  task automatic reset_a(input logic [1:0] m, input logic [11:0] s);
    @(negedge clk);
    mode_a = m; solid_a = s; rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic adv_a(input int edges);
    repeat (edges) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_fs_a(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!fs_a && cnt < 400);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] solid;
    int          x;
    int          y;
    logic [11:0] rgb;
    logic        de;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int cnt, hs_low, vs_low, first_h, first_v;

    tbl[0]  = '{2'd0, 12'h000, 0, 0, 12'hFFF, 1'b1};
    tbl[1]  = '{2'd0, 12'h000, 1, 0, 12'hFF0, 1'b1};
    tbl[2]  = '{2'd0, 12'h000, 2, 0, 12'h0FF, 1'b1};
    tbl[3]  = '{2'd0, 12'h000, 3, 0, 12'h0F0, 1'b1};
    tbl[4]  = '{2'd0, 12'h000, 5, 0, 12'hF00, 1'b1};
    tbl[5]  = '{2'd0, 12'h000, 6, 3, 12'h00F, 1'b1};
    tbl[6]  = '{2'd0, 12'h000, 7, 1, 12'h000, 1'b1};
    tbl[7]  = '{2'd0, 12'h000, 8, 0, 12'h000, 1'b0};
    tbl[8]  = '{2'd0, 12'h000, 3, 5, 12'h000, 1'b0};
    tbl[9]  = '{2'd1, 12'h000, 4, 1, 12'h0FF, 1'b1};
    tbl[10] = '{2'd1, 12'h000, 7, 2, 12'hF0F, 1'b1};
    tbl[11] = '{2'd1, 12'h000, 0, 3, 12'h00F, 1'b1};
    tbl[12] = '{2'd2, 12'h000, 0, 0, 12'h000, 1'b1};
    tbl[13] = '{2'd2, 12'h000, 2, 0, 12'hFFF, 1'b1};
    tbl[14] = '{2'd2, 12'h000, 2, 2, 12'h000, 1'b1};
    tbl[15] = '{2'd2, 12'h000, 1, 3, 12'hFFF, 1'b1};
    tbl[16] = '{2'd3, 12'hA5C, 6, 2, 12'hA5C, 1'b1};
    tbl[17] = '{2'd3, 12'hA5C, 9, 2, 12'h000, 1'b0};

    rst_a = 1'b1; rst_b = 1'b1;
    mode_a = 2'd0; mode_b = 2'd0; solid_a = 12'h000; solid_b = 12'h000;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;

    // Pattern vectors, each from a fresh frame on instance A
    for (int i = 0; i < 18; i++) begin
      reset_a(tbl[i].mode, tbl[i].solid);
      adv_a((tbl[i].y * HT + tbl[i].x + 1) * 2);
      $display("vec %0d mode=%0d pix=(%0d,%0d) rgb=%h de=%b", i, tbl[i].mode,
               px_a, py_a, {r_a, g_a, b_a}, de_a);
      check($sformatf("vec%0d", i), {12'b0, r_a, g_a, b_a, de_a, px_a, py_a},
            {12'b0, tbl[i].rgb, tbl[i].de, 4'(tbl[i].x), 3'(tbl[i].y)});
    end

    // FRAME_START latency and period, sync pulse widths/positions
    reset_a(2'd0, 12'h000);
    wait_fs_a(cnt);
    $display("first FRAME_START after %0d CLK", cnt);
    check("fs_first", 32'(cnt), 32'd2);
    wait_fs_a(cnt);
    $display("frame period %0d CLK", cnt);
    check("fs_period", 32'(cnt), 32'(FT * 2));
    hs_low = 0; vs_low = 0; first_h = -1; first_v = -1;
    repeat (FT * 2) begin
      @(posedge clk); #1;
      if (!hs_a) begin hs_low++; if (first_h < 0) first_h = int'(px_a); end
      if (!vs_a) begin vs_low++; if (first_v < 0) first_v = int'(py_a); end
    end
    $display("hsync low %0d CLK from h=%0d, vsync low %0d CLK from v=%0d",
             hs_low, first_h, vs_low, first_v);
    check("hs_low_clk", 32'(hs_low), 32'(VT * HS * 2));
    check("hs_start_h", 32'(first_h), 32'(HA + HF));
    check("vs_low_clk", 32'(vs_low), 32'(HT * VS * 2));
    check("vs_start_v", 32'(first_v), 32'(VA + VF));

    // Mode/colour latched per frame: mid-frame change is ignored until next frame
    reset_a(2'd3, 12'hA5C);
    adv_a((2 * HT + 1) * 2);
    check("solid_line2", {20'b0, r_a, g_a, b_a}, 32'h0000_0A5C);
    @(negedge clk);
    mode_a = 2'd0; solid_a = 12'h123;
    adv_a((3 * HT + 2 + 1) * 2 - (2 * HT + 1) * 2 - 1);
    $display("after mode change pix=(%0d,%0d) rgb=%h", px_a, py_a, {r_a, g_a, b_a});
    check("solid_hold", {13'b0, r_a, g_a, b_a, px_a, py_a}, {13'b0, 12'hA5C, 4'd2, 3'd3});
    adv_a((FT + 2 + 1) * 2 - (3 * HT + 2 + 1) * 2);
    $display("next frame pix=(%0d,%0d) rgb=%h", px_a, py_a, {r_a, g_a, b_a});
    check("bars_next", {13'b0, r_a, g_a, b_a, px_a, py_a}, {13'b0, 12'h0FF, 4'd2, 3'd0});

    // Reset mid-frame at (5,2)
    reset_a(2'd0, 12'h000);
    adv_a((2 * HT + 5 + 1) * 2);
    check("pre_rst_pix", {25'b0, px_a, py_a}, {25'b0, 4'd5, 3'd2});
    rst_a = 1'b1;
    @(negedge clk);
    $display("mid-frame reset hs=%b vs=%b de=%b pix=(%0d,%0d)", hs_a, vs_a, de_a, px_a, py_a);
    check("rst_state", pack(hs_a, vs_a, de_a, fs_a, {r_a, g_a, b_a}, px_a, py_a),
          pack(1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 4'h0, 3'h0));
    rst_a = 1'b0;
    wait_fs_a(cnt);
    check("rst_fs_first", 32'(cnt), 32'd2);

    // Randomised run, both instances tracked by the scoreboard
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_a = ($urandom_range(0, 499) == 0);
      rst_b = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) mode_a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) mode_b = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) solid_a = 12'($urandom);
      if ($urandom_range(0, 29) == 0) solid_b = 12'($urandom);
    end
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
